// File: rtl/gsim_mem_arbiter.sv
// Shares the matrix-memory read port between two GSIM solver engines: round-robin issue,
// in-order tag FIFO of outstanding reads, and routing of each returned row to its issuer.
module gsim_mem_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 256
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [1:0]    i_req_rreq,
  input  logic [AW-1:0] i_req_addr0,
  input  logic [AW-1:0] i_req_addr1,
  output logic [1:0]    o_req_rrdy,
  output logic [DW-1:0] o_req_dout,
  output logic [1:0]    o_req_dout_vld,
  output logic          o_mem_rreq,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_rrdy,
  input  logic [DW-1:0] i_mem_dout,
  input  logic          i_mem_dout_vld,
  output logic          o_busy,
  output logic          o_err
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(OUTSTANDING);

  // One tag bit per slot: the engine that issued the read held in that slot.
  logic [OUTSTANDING-1:0] tag_q;
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   pref_q;
  logic [DW-1:0]          dout_q;
  logic [1:0]             dout_vld_q;
  logic                   err_q;

  logic grant;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_tag;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  // A lone requester always wins; a tie goes to the preferred engine.
  always_comb begin
    case (i_req_rreq)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = pref_q;
    endcase
  end

  assign o_mem_rreq = (|i_req_rreq) && !full;
  assign o_mem_addr = grant ? i_req_addr1 : i_req_addr0;
  assign push       = o_mem_rreq && i_mem_rrdy;

  assign o_req_rrdy[0] = push && !grant && i_req_rreq[0];
  assign o_req_rrdy[1] = push &&  grant && i_req_rreq[1];

  assign pop      = i_mem_dout_vld && !empty;
  assign head_tag = tag_q[rd_ptr_q];

  // Tag FIFO storage, pointers and occupancy. Full blocks push even if a pop lands this cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Round-robin pointer only moves on an accepted issue, so a refused winner keeps winning.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pref_q <= 1'b0;
    end else if (push) begin
      pref_q <= ~grant;
    end
  end

  // Return path: one registered stage, data held between responses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dout_q     <= '0;
      dout_vld_q <= 2'b00;
    end else begin
      dout_vld_q <= pop ? {head_tag, ~head_tag} : 2'b00;
      if (pop) begin
        dout_q <= i_mem_dout;
      end
    end
  end

  // A response with nothing in flight is dropped and flagged until reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else if (i_mem_dout_vld && empty) begin
      err_q <= 1'b1;
    end
  end

  assign o_req_dout     = dout_q;
  assign o_req_dout_vld = dout_vld_q;
  assign o_busy         = !empty;
  assign o_err          = err_q;

endmodule

// File: tb/tb_gsim_mem_arbiter.sv
// Bench for gsim_mem_arbiter: a vector table, directed multi-cycle corner cases, and a
// randomized run checked every cycle against a queue-based reference model.
module tb_gsim_mem_arbiter;
  localparam int OUT = 4;
  localparam int AW  = 10;
  localparam int DW  = 256;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [1:0]    rreq  = 2'b00;
  logic [AW-1:0] a0    = '0;
  logic [AW-1:0] a1    = '0;
  logic          mrrdy = 1'b0;
  logic [DW-1:0] mdout = '0;
  logic          mvld  = 1'b0;
  logic [1:0]    rrdy;
  logic [DW-1:0] dout;
  logic [1:0]    dvld;
  logic          mreq;
  logic [AW-1:0] maddr;
  logic          busy;
  logic          err;

  gsim_mem_arbiter #(.OUTSTANDING(OUT), .AW(AW), .DW(DW)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req_rreq     (rreq),
    .i_req_addr0    (a0),
    .i_req_addr1    (a1),
    .o_req_rrdy     (rrdy),
    .o_req_dout     (dout),
    .o_req_dout_vld (dvld),
    .o_mem_rreq     (mreq),
    .o_mem_addr     (maddr),
    .i_mem_rrdy     (mrrdy),
    .i_mem_dout     (mdout),
    .i_mem_dout_vld (mvld),
    .o_busy         (busy),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: in-flight tags in issue order, the engine to favour on a tie,
  // and the expected registered return outputs.
  int            tagq[$];
  bit            pref  = 1'b0;
  logic [1:0]    m_vld = 2'b00;
  logic [DW-1:0] m_dout = '0;
  logic          m_err = 1'b0;

  // Memory responder: returns reads in order, no earlier than their due cycle.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t pend[$];

  int cyc      = 0;
  int latency  = 1;
  bit auto_mem = 1'b0;
  bit rand_ret = 1'b0;
  bit rand_lat = 1'b0;

  int            issue_cyc[$];
  logic [AW-1:0] issue_addr[$];

  typedef struct {
    logic [1:0]    rreq;
    logic          mrrdy;
    logic          mvld;
    logic [1:0]    e_rrdy;
    logic          e_mreq;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_vld;
    logic          e_busy;
  } vec_t;

  task automatic tally(input string nm, input bit ok, input string got, input string want);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s expected %s", nm, got, want);
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    tally(nm, a === e, $sformatf("%0h", a), $sformatf("%0h", e));
  endtask

  task automatic chk2(input string nm, input logic [1:0] a, input logic [1:0] e);
    tally(nm, a === e, $sformatf("%0h", a), $sformatf("%0h", e));
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] a, input logic [AW-1:0] e);
    tally(nm, a === e, $sformatf("%0h", a), $sformatf("%0h", e));
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    tally(nm, a === e, $sformatf("%0h", a), $sformatf("%0h", e));
  endtask

  task automatic chki(input string nm, input int a, input int e);
    tally(nm, a == e, $sformatf("%0d", a), $sformatf("%0d", e));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {8{$urandom}};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a, input int c);
    return {a, 22'(c), {7{$urandom}}};
  endfunction

  task automatic set_mem();
    if (pend.size() > 0 && pend[0].due <= cyc && (!rand_ret || $urandom_range(0, 2) != 0)) begin
      mvld  = 1'b1;
      mdout = pend[0].data;
    end else begin
      mvld  = 1'b0;
      mdout = rnd_data();
    end
  endtask

  // Checks every output against the model mid-cycle, then advances model and clock.
  task automatic step(input bit waited, output logic [1:0] acc);
    bit   g;
    bit   e_mreq;
    bit   iss;
    int   t;
    int   lat;
    rsp_t r;
    if (!waited) #4;
    g      = (rreq == 2'b11) ? pref : rreq[1];
    e_mreq = (rreq != 2'b00) && (tagq.size() < OUT);
    iss    = e_mreq && mrrdy;
    acc    = iss ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk2("req_rrdy", rrdy, acc);
    chk1("mem_rreq", mreq, e_mreq);
    if (e_mreq) chka("mem_addr", maddr, g ? a1 : a0);
    chk1("busy", busy, tagq.size() != 0);
    chk2("dout_vld", dvld, m_vld);
    chkd("dout", dout, m_dout);
    chk1("err", err, m_err);
    if (mvld) begin
      if (tagq.size() > 0) begin
        t      = tagq.pop_front();
        m_vld  = (t != 0) ? 2'b10 : 2'b01;
        m_dout = mdout;
      end else begin
        m_vld = 2'b00;
        m_err = 1'b1;
      end
      if (auto_mem && pend.size() > 0) pend.delete(0);
    end else begin
      m_vld = 2'b00;
    end
    if (iss) begin
      tagq.push_back(int'(g));
      pref = !g;
      issue_cyc.push_back(cyc);
      issue_addr.push_back(g ? a1 : a0);
      lat    = rand_lat ? int'($urandom_range(1, 6)) : latency;
      r.due  = cyc + lat;
      r.data = mk_data(g ? a1 : a0, cyc);
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible before any edge.
  task automatic apply_reset();
    rst  = 1'b1;
    mvld = 1'b0;
    #1;
    tagq.delete();
    pref   = 1'b0;
    m_vld  = 2'b00;
    m_dout = '0;
    m_err  = 1'b0;
    chk1("reset_busy", busy, 1'b0);
    chk2("reset_dout_vld", dvld, 2'b00);
    chkd("reset_dout", dout, '0);
    chk1("reset_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    logic [1:0] acc;
    rreq = 2'b00;
    for (int i = 0; i < 60 && (tagq.size() > 0 || pend.size() > 0); i++) begin
      set_mem();
      step(1'b0, acc);
    end
    chk1("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[9];
    logic [1:0] acc;
    logic [1:0] act;
    int         b;

    // Both engines at 0x010 / 0x200 unless a row says only one requests.
    tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 10'h010, 2'b00, 1'b0};
    tbl[1] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 10'h200, 2'b00, 1'b1};
    tbl[2] = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 10'h010, 2'b01, 1'b1};
    tbl[3] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 10'h200, 2'b10, 1'b0};
    tbl[4] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 10'h000, 2'b00, 1'b1};
    tbl[5] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 10'h000, 2'b10, 1'b0};
    tbl[6] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 10'h010, 2'b00, 1'b0};
    tbl[7] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 10'h000, 2'b00, 1'b1};
    tbl[8] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 10'h000, 2'b01, 1'b0};

    apply_reset();

    a0 = 10'h010;
    a1 = 10'h200;
    for (int i = 0; i < 9; i++) begin
      rreq  = tbl[i].rreq;
      mrrdy = tbl[i].mrrdy;
      mvld  = tbl[i].mvld;
      mdout = rnd_data();
      #4;
      chk2($sformatf("tbl%0d_rrdy", i), rrdy, tbl[i].e_rrdy);
      chk1($sformatf("tbl%0d_mreq", i), mreq, tbl[i].e_mreq);
      if (tbl[i].e_mreq) chka($sformatf("tbl%0d_addr", i), maddr, tbl[i].e_addr);
      chk2($sformatf("tbl%0d_vld", i), dvld, tbl[i].e_vld);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      step(1'b1, acc);
    end
    pend.delete();
    auto_mem = 1'b1;

    // Engine 0 alone, latency 1: four back-to-back issues.
    latency = 1;
    a0      = 10'h000;
    rreq    = 2'b01;
    mrrdy   = 1'b1;
    b       = issue_cyc.size();
    for (int i = 0; i < 20 && issue_cyc.size() - b < 4; i++) begin
      set_mem();
      step(1'b0, acc);
      if (acc[0]) a0 = a0 + 1'b1;
    end
    drain();
    chki("s1_issues", issue_cyc.size() - b, 4);
    if (issue_cyc.size() >= b + 4) begin
      chki("s1_consecutive", issue_cyc[b+3] - issue_cyc[b], 3);
      for (int k = 0; k < 4; k++) chka("s1_addr", issue_addr[b+k], AW'(k));
    end

    // Both engines every cycle: grants alternate, engine 1 first after engine 0 went last.
    latency = 2;
    a0      = 10'h010;
    a1      = 10'h200;
    rreq    = 2'b11;
    b       = issue_cyc.size();
    for (int i = 0; i < 8; i++) begin
      set_mem();
      step(1'b0, acc);
    end
    drain();
    chki("s2_issues", issue_cyc.size() - b, 8);
    if (issue_cyc.size() >= b + 8) begin
      chka("s2_first", issue_addr[b], 10'h200);
      for (int k = 1; k < 8; k++) chk1("s2_alternate", issue_addr[b+k] != issue_addr[b+k-1], 1'b1);
    end

    // Latency 8: FIFO fills after four, next issue only the cycle after the first pop.
    latency = 8;
    a0      = 10'h100;
    rreq    = 2'b01;
    b       = issue_cyc.size();
    for (int i = 0; i < 14; i++) begin
      set_mem();
      step(1'b0, acc);
      if (acc[0]) a0 = a0 + 1'b1;
    end
    drain();
    chk1("s3_enough_issues", issue_cyc.size() >= b + 5, 1'b1);
    if (issue_cyc.size() >= b + 5) begin
      chki("s3_first_four", issue_cyc[b+3] - issue_cyc[b], 3);
      chki("s3_after_full", issue_cyc[b+4] - issue_cyc[b], 9);
    end

    // Engine 1 preferred, memory refuses for three cycles: winner must not move.
    latency = 1;
    a0      = 10'h011;
    a1      = 10'h211;
    rreq    = 2'b11;
    mrrdy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_mem();
      #4;
      chk2("s4_rrdy_blocked", rrdy, 2'b00);
      chka("s4_winner", maddr, 10'h211);
      step(1'b1, acc);
    end
    mrrdy = 1'b1;
    set_mem();
    #4;
    chk2("s4_first_accept", rrdy, 2'b10);
    step(1'b1, acc);
    drain();

    // Response with nothing in flight: dropped, sticky error.
    auto_mem = 1'b0;
    mvld     = 1'b1;
    mdout    = rnd_data();
    step(1'b0, acc);
    mvld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk2("s5_no_vld", dvld, 2'b00);
      chk1("s5_err_sticky", err, 1'b1);
      step(1'b1, acc);
    end
    auto_mem = 1'b1;
    apply_reset();

    // Reset with three reads in flight; stale responses then count as spurious.
    latency = 8;
    a0      = 10'h0a0;
    rreq    = 2'b01;
    mrrdy   = 1'b1;
    b       = issue_cyc.size();
    for (int i = 0; i < 10 && issue_cyc.size() - b < 3; i++) begin
      set_mem();
      step(1'b0, acc);
      if (acc[0]) a0 = a0 + 1'b1;
    end
    rreq = 2'b00;
    chk1("s6_in_flight", busy, 1'b1);
    apply_reset();
    drain();
    chk1("s6_stale_err", err, 1'b1);
    latency = 1;
    a1      = 10'h3c3;
    rreq    = 2'b10;
    b       = issue_cyc.size();
    for (int i = 0; i < 10 && issue_cyc.size() - b < 1; i++) begin
      set_mem();
      step(1'b0, acc);
    end
    drain();
    chki("s6_served_after_reset", issue_cyc.size() - b, 1);

    // Random traffic: engines hold address until accepted, memory stalls and delays at random.
    apply_reset();
    rand_ret = 1'b1;
    rand_lat = 1'b1;
    act      = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if (!act[0] && $urandom_range(0, 1) != 0) begin
        act[0] = 1'b1;
        a0     = AW'($urandom);
      end
      if (!act[1] && $urandom_range(0, 1) != 0) begin
        act[1] = 1'b1;
        a1     = AW'($urandom);
      end
      rreq  = act;
      mrrdy = ($urandom_range(0, 3) != 0);
      set_mem();
      step(1'b0, acc);
      act = act & ~acc;
    end
    rand_ret = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
